// File: rtl/convolucion_p3.sv
// convolucion_p3: full linear convolution Z = Y * H over external synchronous-read RAMs,
// with runtime sizes, signed/unsigned operands, saturating or wrapping output and abort.
module convolucion_p3 #(
   parameter int unsigned DATA_WIDTH        = 8,
   parameter int unsigned DATA_WIDTH_OUT    = 16,
   parameter int unsigned ADDRESS_WIDTH     = 5,
   parameter int unsigned ADDRESS_WIDTH_OUT = 6,
   parameter int unsigned READ_LATENCY      = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start_i,
   input  logic                         abort_i,
   input  logic                         signed_i,
   input  logic                         sat_i,
   input  logic [ADDRESS_WIDTH:0]       size_y_i,
   input  logic [ADDRESS_WIDTH:0]       size_h_i,
   input  logic [DATA_WIDTH-1:0]        data_y_i,
   input  logic [DATA_WIDTH-1:0]        data_h_i,
   output logic [ADDRESS_WIDTH-1:0]     mem_y_addr_o,
   output logic [ADDRESS_WIDTH-1:0]     mem_h_addr_o,
   output logic [ADDRESS_WIDTH_OUT-1:0] mem_z_addr_o,
   output logic [DATA_WIDTH_OUT-1:0]    data_z_o,
   output logic                         write_o,
   output logic                         busy_o,
   output logic                         done_o
);

   localparam int unsigned ACC = 2 * DATA_WIDTH + ADDRESS_WIDTH + 1;
   // Index width holds i up to Ly+Lh-2 and the intermediate i+1-Ly without overflow.
   localparam int unsigned IW  = ADDRESS_WIDTH + 2;

   localparam logic [DATA_WIDTH_OUT-1:0] SMAX = {1'b0, {(DATA_WIDTH_OUT-1){1'b1}}};
   localparam logic [DATA_WIDTH_OUT-1:0] SMIN = {1'b1, {(DATA_WIDTH_OUT-1){1'b0}}};
   localparam logic [DATA_WIDTH_OUT-1:0] UMAX = {DATA_WIDTH_OUT{1'b1}};

   typedef enum logic [2:0] {StIdle, StFetch, StDrain, StWrite, StDone} state_t;

   state_t                  state;
   logic                    sgn_mode;
   logic                    sat_mode;
   logic [IW-1:0]           len_y;
   logic [IW-1:0]           len_h;
   logic [IW-1:0]           last_i;
   logic [IW-1:0]           i_idx;
   logic [IW-1:0]           j_idx;
   logic [IW-1:0]           j_end;
   logic [1:0]              drain_cnt;
   logic [READ_LATENCY-1:0] vld;
   logic [ACC-1:0]          acc;
   logic                    wr_pulse;
   logic                    done_pulse;

   logic [ACC-1:0]          ext_y;
   logic [ACC-1:0]          ext_h;
   logic [ACC-1:0]          prod;
   logic [ACC-1:0]          acc_sum;
   logic [DATA_WIDTH_OUT-1:0] z_val;
   logic [IW-1:0]           i_nxt;
   logic [IW-1:0]           j_lo;
   logic [IW-1:0]           j_hi;
   logic [IW-1:0]           j_inc;

   assign ext_y   = {{(ACC-DATA_WIDTH){sgn_mode & data_y_i[DATA_WIDTH-1]}}, data_y_i};
   assign ext_h   = {{(ACC-DATA_WIDTH){sgn_mode & data_h_i[DATA_WIDTH-1]}}, data_h_i};
   // Modular ACC-bit product is exact for both signed and unsigned operands.
   assign prod    = ext_y * ext_h;
   assign acc_sum = vld[READ_LATENCY-1] ? acc + prod : acc;

   always_comb begin
      z_val = acc_sum[DATA_WIDTH_OUT-1:0];
      if (sat_mode) begin
         if (sgn_mode) begin
            if (!acc_sum[ACC-1] && (|acc_sum[ACC-2:DATA_WIDTH_OUT-1])) begin
               z_val = SMAX;
            end else if (acc_sum[ACC-1] && !(&acc_sum[ACC-2:DATA_WIDTH_OUT-1])) begin
               z_val = SMIN;
            end
         end else if (|acc_sum[ACC-1:DATA_WIDTH_OUT]) begin
            z_val = UMAX;
         end
      end
   end

   // Term range for the next output index: j in [max(0, i-Ly+1), min(i, Lh-1)].
   assign i_nxt = i_idx + IW'(1);
   assign j_lo  = (i_nxt >= len_y) ? (i_nxt - len_y + IW'(1)) : '0;
   assign j_hi  = (i_nxt < (len_h - IW'(1))) ? i_nxt : (len_h - IW'(1));
   assign j_inc = j_idx + IW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= StIdle;
         sgn_mode     <= 1'b0;
         sat_mode     <= 1'b0;
         len_y        <= '0;
         len_h        <= '0;
         last_i       <= '0;
         i_idx        <= '0;
         j_idx        <= '0;
         j_end        <= '0;
         drain_cnt    <= '0;
         vld          <= '0;
         acc          <= '0;
         wr_pulse     <= 1'b0;
         done_pulse   <= 1'b0;
         mem_y_addr_o <= '0;
         mem_h_addr_o <= '0;
         mem_z_addr_o <= '0;
         data_z_o     <= '0;
      end else begin
         vld[0] <= (state == StFetch);
         for (int k = 1; k < int'(READ_LATENCY); k++) begin
            vld[k] <= vld[k-1];
         end
         if ((state != StIdle) && abort_i) begin
            state      <= StIdle;
            vld        <= '0;
            acc        <= '0;
            wr_pulse   <= 1'b0;
            done_pulse <= 1'b0;
         end else begin
            unique case (state)
               StIdle: begin
                  if (start_i) begin
                     sgn_mode <= signed_i;
                     sat_mode <= sat_i;
                     len_y    <= IW'(size_y_i);
                     len_h    <= IW'(size_h_i);
                     last_i   <= IW'(size_y_i) + IW'(size_h_i) - IW'(2);
                     acc      <= '0;
                     if ((size_y_i == '0) || (size_h_i == '0)) begin
                        state      <= StDone;
                        done_pulse <= 1'b1;
                     end else begin
                        state        <= StFetch;
                        i_idx        <= '0;
                        j_idx        <= '0;
                        j_end        <= '0;
                        mem_y_addr_o <= '0;
                        mem_h_addr_o <= '0;
                     end
                  end
               end
               StFetch: begin
                  acc <= acc_sum;
                  if (j_idx == j_end) begin
                     state     <= StDrain;
                     drain_cnt <= '0;
                  end else begin
                     j_idx        <= j_inc;
                     mem_h_addr_o <= j_inc[ADDRESS_WIDTH-1:0];
                     mem_y_addr_o <= ADDRESS_WIDTH'(i_idx - j_inc);
                  end
               end
               StDrain: begin
                  if (drain_cnt == 2'(READ_LATENCY - 1)) begin
                     state        <= StWrite;
                     data_z_o     <= z_val;
                     mem_z_addr_o <= ADDRESS_WIDTH_OUT'(i_idx);
                     wr_pulse     <= 1'b1;
                     acc          <= '0;
                  end else begin
                     acc       <= acc_sum;
                     drain_cnt <= drain_cnt + 2'd1;
                  end
               end
               StWrite: begin
                  wr_pulse <= 1'b0;
                  if (i_idx == last_i) begin
                     state      <= StDone;
                     done_pulse <= 1'b1;
                  end else begin
                     state        <= StFetch;
                     i_idx        <= i_nxt;
                     j_idx        <= j_lo;
                     j_end        <= j_hi;
                     mem_h_addr_o <= j_lo[ADDRESS_WIDTH-1:0];
                     mem_y_addr_o <= ADDRESS_WIDTH'(i_nxt - j_lo);
                  end
               end
               StDone: begin
                  done_pulse <= 1'b0;
                  state      <= StIdle;
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

   // An abort arriving during WRITE or DONE must kill that cycle's pulse.
   assign write_o = wr_pulse & ~abort_i;
   assign done_o  = done_pulse & ~abort_i;
   assign busy_o  = (state != StIdle);

endmodule
